exe_div_iter: RTL

Parametrised iterative radix-2 divider for the EXE stage. It replaces the vendor divider IP and its hand-rolled tvalid/got bookkeeping with one self-contained unit that has a single valid/ready handshake on each side. One unit serves signed and unsigned div/mod: each operation produces both quotient and remainder. It carries a tag (the destination register) alongside the operation and supports pipeline flush.

---
 rtl/exe_div_iter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/exe_div_iter.sv
// exe_div_iter: iterative restoring radix-2 divider for the EXE stage.
// Takes signed or unsigned operands and produces quotient and remainder
// together. A tag rides alongside each operation, and flush cancels
// whatever is in flight. Handshakes are valid/ready on both sides.
module exe_div_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rawDividend;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_qNeg;
    logic               r_rNeg;
    logic               r_dz;
    logic [TAG_W-1:0]   r_tag;

    logic               w_accept;
    logic               w_dividendNeg;
    logic               w_divisorNeg;
    logic [WIDTH-1:0]   w_absDividend;
    logic [WIDTH-1:0]   w_absDivisor;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;

    // A new request may enter from IDLE, or from DONE while the result leaves.
    // Flush blocks acceptance so a cancelled cycle can never start a new operation.
    assign in_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    // Take magnitudes up front. The core then runs a plain unsigned restoring loop,
    // and the signs are reapplied at the output.
    assign w_dividendNeg = in_signed & in_dividend[WIDTH-1];
    assign w_divisorNeg  = in_signed & in_divisor[WIDTH-1];
    assign w_absDividend = w_dividendNeg ? -in_dividend : in_dividend;
    assign w_absDivisor  = w_divisorNeg  ? -in_divisor  : in_divisor;

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits.
    // When the trial subtraction succeeds, the difference is below the divisor,
    // so WIDTH bits are enough to hold it.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = w_shift[WIDTH-1:0] - r_divisor;

    // Control FSM and datapath registers. Flush beats both accept and the output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_rawDividend <= '0;
            r_cnt         <= '0;
            r_qNeg        <= 1'b0;
            r_rNeg        <= 1'b0;
            r_dz          <= 1'b0;
            r_tag         <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state       <= CALC;
                        r_rem         <= '0;
                        r_quo         <= w_absDividend;
                        r_divisor     <= w_absDivisor;
                        r_rawDividend <= in_dividend;
                        r_cnt         <= CNT_W'(WIDTH - 1);
                        r_qNeg        <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                        r_rNeg        <= w_dividendNeg;
                        r_dz          <= (in_divisor == '0);
                        r_tag         <= in_tag;
                    end else if (r_state == DONE && out_ready) begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result formatting is combinational from registers. Divide-by-zero returns
    // all ones and the raw dividend, whatever the signedness.
    assign out_quotient  = r_dz ? '1            : (r_qNeg ? -r_quo : r_quo);
    assign out_remainder = r_dz ? r_rawDividend : (r_rNeg ? -r_rem : r_rem);
    assign out_tag       = r_tag;
    assign out_valid     = (r_state == DONE);
    assign busy          = (r_state != IDLE);

endmodule
